// File: rtl/spike_pkg.sv
// Shared definitions for the spike event path: default widths, event word layout
// and refractory FSM states.
package spike_pkg;

  localparam int unsigned DefTsWidth = 24;
  localparam int unsigned DefChWidth = 4;

  // Event word: channel ID in the MSBs, timestamp in the LSBs.
  localparam int unsigned EvTsLsb = 0;

  typedef enum logic [0:0] {
    StArmed,
    StRefract
  } state_e;

  function automatic int unsigned ev_ch_lsb(input int unsigned ts_width);
    return ts_width;
  endfunction

endpackage

// File: rtl/event_fifo.sv
// Synchronous FIFO with registered pointers; a push on a full FIFO is taken only
// when a pop happens in the same cycle.
module event_fifo #(
  parameter int unsigned WIDTH = 28,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FullCount = DEPTH[AW:0];

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_count == FullCount);
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_data    = r_mem[r_rd_ptr];
  assign w_do_pop  = i_pop & ~o_empty;
  assign w_do_push = i_push & (~o_full | w_do_pop);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      unique case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/spike_event_packer.sv
// Turns the per-sample spike level into timestamped events with a refractory
// window, buffers them and streams them out over valid/ready.
module spike_event_packer
  import spike_pkg::*;
#(
  parameter int unsigned TS_WIDTH   = DefTsWidth,
  parameter int unsigned CH_WIDTH   = DefChWidth,
  parameter int unsigned CHANNEL_ID = 0,
  parameter int unsigned REFRACTORY = 30,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_sample_en,
  input  logic                         i_spike_in,
  output logic                         o_ev_valid,
  input  logic                         i_ev_ready,
  output logic [CH_WIDTH+TS_WIDTH-1:0] o_ev_data,
  output logic                         o_overflow,
  output logic [CNT_WIDTH-1:0]         o_event_count,
  output logic [CNT_WIDTH-1:0]         o_drop_count
);

  localparam int unsigned EvWidth  = CH_WIDTH + TS_WIDTH;
  localparam int unsigned EvChLsb  = ev_ch_lsb(TS_WIDTH);
  localparam int unsigned FifoCntW = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned RcntW    = (REFRACTORY > 1) ? $clog2(REFRACTORY) : 1;
  localparam logic [RcntW-1:0]     RcntLoad = RcntW'((REFRACTORY > 0) ? REFRACTORY - 1 : 0);
  localparam logic [CNT_WIDTH-1:0] CntMax   = '1;

  state_e               r_state;
  state_e               w_state_d;
  logic [RcntW-1:0]     r_rcnt;
  logic [RcntW-1:0]     w_rcnt_d;
  logic [TS_WIDTH-1:0]  r_ts;
  logic                 r_prev_spike;
  logic                 r_overflow;
  logic [CNT_WIDTH-1:0] r_event_count;
  logic [CNT_WIDTH-1:0] r_drop_count;

  logic                 w_cand;
  logic                 w_accept;
  logic                 w_pop;
  logic                 w_push;
  logic                 w_drop;
  logic [EvWidth-1:0]   w_ev_word;
  logic [EvWidth-1:0]   w_fifo_data;
  logic                 w_fifo_full;
  logic                 w_fifo_empty;
  logic [FifoCntW-1:0]  w_fifo_count;

  assign w_cand = i_sample_en & i_spike_in & ~r_prev_spike;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= StArmed;
      r_rcnt  <= '0;
    end else begin
      r_state <= w_state_d;
      r_rcnt  <= w_rcnt_d;
    end
  end

  // The window counts samples, so the FSM only moves on sample strobes.
  always_comb begin
    w_state_d = r_state;
    w_rcnt_d  = r_rcnt;
    w_accept  = 1'b0;
    if (i_sample_en) begin
      unique case (r_state)
        StArmed: begin
          if (w_cand) begin
            w_accept = 1'b1;
            if (REFRACTORY > 0) begin
              w_state_d = StRefract;
              w_rcnt_d  = RcntLoad;
            end
          end
        end
        StRefract: begin
          if (r_rcnt == '0) begin
            w_state_d = StArmed;
          end else begin
            w_rcnt_d = r_rcnt - 1'b1;
          end
        end
        default: w_state_d = StArmed;
      endcase
    end
  end

  always_comb begin
    w_ev_word = '0;
    w_ev_word[EvTsLsb +: TS_WIDTH] = r_ts;
    w_ev_word[EvChLsb +: CH_WIDTH] = CH_WIDTH'(CHANNEL_ID);
  end

  assign w_pop  = o_ev_valid & i_ev_ready;
  assign w_push = w_accept & (~w_fifo_full | w_pop);
  assign w_drop = w_accept & w_fifo_full & ~w_pop;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ts          <= '0;
      r_prev_spike  <= 1'b0;
      r_overflow    <= 1'b0;
      r_event_count <= '0;
      r_drop_count  <= '0;
    end else begin
      if (i_sample_en) begin
        r_ts         <= r_ts + 1'b1;
        r_prev_spike <= i_spike_in;
      end
      if (w_push && (r_event_count != CntMax)) begin
        r_event_count <= r_event_count + 1'b1;
      end
      if (w_drop) begin
        r_overflow <= 1'b1;
        if (r_drop_count != CntMax) begin
          r_drop_count <= r_drop_count + 1'b1;
        end
      end
    end
  end

  event_fifo #(
    .WIDTH (EvWidth),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (w_push),
    .i_data  (w_ev_word),
    .i_pop   (w_pop),
    .o_data  (w_fifo_data),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty),
    .o_count (w_fifo_count)
  );

  assign o_ev_valid    = (w_fifo_count != '0);
  assign o_ev_data     = w_fifo_empty ? '0 : w_fifo_data;
  assign o_overflow    = r_overflow;
  assign o_event_count = r_event_count;
  assign o_drop_count  = r_drop_count;

endmodule

// File: tb/tb_spike_event_packer.sv
// Directed bench for spike_event_packer: a sample-distance event model with a
// per-cycle compare, plus literal expectations and a narrow-timestamp instance.
module tb_spike_event_packer;

  localparam int unsigned TsW   = 24;
  localparam int unsigned ChW   = 4;
  localparam int unsigned Refr  = 30;
  localparam int unsigned Depth = 8;
  localparam int unsigned CntW  = 16;
  localparam int          Big   = 1000000;
  localparam int          CMax  = (1 << CntW) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst, sample_en, spike_in, ev_ready;
  logic               ev_valid, overflow;
  logic [ChW+TsW-1:0] ev_data;
  logic [CntW-1:0]    event_count, drop_count;

  logic               wr_rst, wr_en, wr_spike, wr_ready;
  logic               wr_valid, wr_overflow;
  logic [7:0]         wr_data;
  logic [CntW-1:0]    wr_evc, wr_drc;

  spike_event_packer #(
    .TS_WIDTH(TsW), .CH_WIDTH(ChW), .CHANNEL_ID(0), .REFRACTORY(Refr),
    .FIFO_DEPTH(Depth), .CNT_WIDTH(CntW)
  ) u_dut (
    .i_clk(clk), .i_rst(rst), .i_sample_en(sample_en), .i_spike_in(spike_in),
    .o_ev_valid(ev_valid), .i_ev_ready(ev_ready), .o_ev_data(ev_data),
    .o_overflow(overflow), .o_event_count(event_count), .o_drop_count(drop_count)
  );

  spike_event_packer #(
    .TS_WIDTH(4), .CH_WIDTH(4), .CHANNEL_ID(3), .REFRACTORY(0),
    .FIFO_DEPTH(8), .CNT_WIDTH(CntW)
  ) u_dut_wrap (
    .i_clk(clk), .i_rst(wr_rst), .i_sample_en(wr_en), .i_spike_in(wr_spike),
    .o_ev_valid(wr_valid), .i_ev_ready(wr_ready), .o_ev_data(wr_data),
    .o_overflow(wr_overflow), .o_event_count(wr_evc), .o_drop_count(wr_drc)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Model: an edge is an event when more than Refr samples have passed since the last one.
  logic [ChW+TsW-1:0] mq[$];
  logic [ChW+TsW-1:0] log_q[$];
  int m_ts, m_since, m_evc, m_drc;
  bit m_prev, m_ovf;
  bit cmp_en = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      mq.delete();
      m_ts = 0; m_prev = 0; m_since = Big; m_ovf = 0; m_evc = 0; m_drc = 0;
    end else begin
      if (mq.size() != 0 && ev_ready) void'(mq.pop_front());
      if (sample_en) begin
        if (m_since < Big) m_since++;
        if (spike_in && !m_prev && m_since > int'(Refr)) begin
          m_since = 0;
          if (mq.size() < int'(Depth)) begin
            mq.push_back({ChW'(0), TsW'(m_ts)});
            if (m_evc < CMax) m_evc++;
          end else begin
            m_ovf = 1;
            if (m_drc < CMax) m_drc++;
          end
        end
        m_prev = spike_in;
        m_ts   = (m_ts + 1) % (1 << TsW);
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("ev_valid", ev_valid, mq.size() != 0);
      check("ev_data", ev_data, (mq.size() != 0) ? mq[0] : '0);
      check("overflow", overflow, m_ovf);
      check("event_count", event_count, m_evc);
      check("drop_count", drop_count, m_drc);
      if (ev_valid && ev_ready) log_q.push_back(ev_data);
    end
  end

  task automatic drive(input bit en, input bit s, input bit rdy);
    @(posedge clk);
    #1;
    rst = 1'b0; sample_en = en; spike_in = s; ev_ready = rdy;
  endtask

  task automatic do_reset(input bit en, input bit s, input bit rdy);
    @(posedge clk);
    #1;
    rst = 1'b1; sample_en = en; spike_in = s; ev_ready = rdy;
  endtask

  initial begin
    rst = 1'b1; sample_en = 1'b0; spike_in = 1'b0; ev_ready = 1'b0;
    wr_rst = 1'b1; wr_en = 1'b0; wr_spike = 1'b0; wr_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    cmp_en = 1'b1;
    @(negedge clk);
    check("rst_valid", ev_valid, 0);
    check("rst_data", ev_data, 0);
    check("rst_overflow", overflow, 0);
    check("rst_evc", event_count, 0);
    check("rst_drc", drop_count, 0);

    // Single event from a 10-sample high level starting at sample 5.
    log_q.delete();
    for (int n = 0; n < 5; n++) drive(1, 0, 1);
    drive(1, 1, 1);
    @(negedge clk);
    check("t1_not_early", ev_valid, 0);
    @(negedge clk);
    check("t1_latency_valid", ev_valid, 1);
    check("t1_latency_data", ev_data, 28'd5);
    for (int n = 7; n < 15; n++) drive(1, 1, 1);
    @(negedge clk);
    check("t1_one_cycle", ev_valid, 0);
    for (int n = 15; n < 50; n++) drive(1, 0, 1);
    @(negedge clk);
    check("t1_words", log_q.size(), 1);
    check("t1_word0", log_q[0], 28'd5);
    check("t1_evc", event_count, 1);

    // Refractory window.
    do_reset(0, 0, 1);
    drive(0, 0, 1);
    log_q.delete();
    for (int n = 0; n < 80; n++) drive(1, (n == 10 || n == 25 || n == 41 || n == 42), 1);
    drive(0, 0, 1);
    drive(0, 0, 1);
    @(negedge clk);
    check("t2_words", log_q.size(), 2);
    check("t2_word0", log_q[0], 28'd10);
    check("t2_word1", log_q[1], 28'd41);
    check("t2_drc", drop_count, 0);
    check("t2_evc", event_count, 2);

    // Backpressure and overflow: ten isolated pulses with the sink stalled.
    do_reset(0, 0, 0);
    drive(0, 0, 0);
    log_q.delete();
    for (int n = 0; n < 330; n++) drive(1, (n % 32 == 0 && n <= 288), 0);
    @(negedge clk);
    check("t3_stall_valid", ev_valid, 1);
    check("t3_stall_head", ev_data, 28'd0);
    check("t3_overflow", overflow, 1);
    check("t3_drc", drop_count, 2);
    check("t3_evc", event_count, 8);

    // Full FIFO, event at sample 330 coincides with a pop.
    drive(1, 1, 1);
    drive(1, 0, 0);
    @(negedge clk);
    check("t4_evc", event_count, 9);
    check("t4_drc", drop_count, 2);
    check("t4_popped", log_q.size(), 1);
    check("t4_new_head", ev_data, 28'd32);
    for (int n = 0; n < 12; n++) drive(0, 0, 1);
    @(negedge clk);
    check("t4_words", log_q.size(), 9);
    for (int i = 0; i < 8; i++) check("t4_order", log_q[i], 28'(i * 32));
    check("t4_last", log_q[8], 28'd330);

    // Reset while refracting with three queued events; rst overrides an edge.
    for (int k = 0; k < 125; k++) drive(1, (k == 40 || k == 80 || k == 120), 0);
    @(negedge clk);
    check("t6_pre_valid", ev_valid, 1);
    do_reset(1, 1, 1);
    drive(1, 1, 1);
    @(negedge clk);
    check("t6_valid", ev_valid, 0);
    check("t6_overflow", overflow, 0);
    check("t6_evc", event_count, 0);
    check("t6_drc", drop_count, 0);
    @(negedge clk);
    check("t6_first_valid", ev_valid, 1);
    check("t6_first_ts", ev_data, 28'd0);
    check("t6_first_evc", event_count, 1);
    drive(0, 0, 1);
    drive(0, 0, 1);

    // Timestamp wrap on a 4-bit counter, channel ID 3.
    for (int n = 0; n < 20; n++) begin
      @(posedge clk);
      #1;
      wr_rst = 1'b0; wr_en = 1'b1; wr_spike = (n == 14 || n == 17);
    end
    @(posedge clk);
    #1;
    wr_en = 1'b0; wr_spike = 1'b0;
    @(negedge clk);
    check("t5_valid", wr_valid, 1);
    check("t5_word0", wr_data, 8'h3E);
    check("t5_evc", wr_evc, 2);
    check("t5_drc", wr_drc, 0);
    check("t5_overflow", wr_overflow, 0);
    @(posedge clk);
    #1;
    wr_ready = 1'b1;
    @(posedge clk);
    #1;
    wr_ready = 1'b0;
    @(negedge clk);
    check("t5_valid1", wr_valid, 1);
    check("t5_word1", wr_data, 8'h31);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/spike_event_packer.md
Name: spike_event_packer

Overview:
- Sits directly downstream of the NEO spike detector.
- Turns its per-sample spike_detected level into discrete, timestamped spike events.
- Enforces a refractory period, buffers events in a small FIFO, and presents them on a valid/ready stream to the event-logging/UART stage.
- Counts accepted and dropped events for diagnostics.

Parameters:
- TS_WIDTH, 24, width of the sample timestamp counter (wraps).
- CH_WIDTH, 4, width of the channel-ID field.
- CHANNEL_ID, 0, constant channel ID placed in every event word.
- REFRACTORY, 30, samples ignored after an accepted event; 0 = edge detection only.
- FIFO_DEPTH, 8, event FIFO entries; must be a power of two, at least 2.
- CNT_WIDTH, 16, width of the saturating event/drop counters.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- sample_en  in  1  one-cycle strobe, high when spike_in carries a new sample
- spike_in  in  1  spike_detected level from the NEO stage
- ev_valid  out  1  event word available
- ev_ready  in  1  downstream accepts the event word
- ev_data  out  CH_WIDTH+TS_WIDTH  {CHANNEL_ID, timestamp}
- overflow  out  1  sticky; set when an event was dropped because the FIFO was full
- event_count  out  CNT_WIDTH  saturating count of events pushed into the FIFO
- drop_count  out  CNT_WIDTH  saturating count of events dropped on a full FIFO

Behaviour:
Reset (synchronous, clk edge with rst=1):
- ts=0, prev_spike=0, state=ARMED, refractory counter=0, FIFO empty.
- ev_valid=0, ev_data=0, overflow=0, event_count=0, drop_count=0.
- rst overrides all other inputs that cycle; events in flight and FIFO contents are discarded.

Timestamp:
- ts increments by 1 on every cycle with sample_en=1.
- Wraps from 2^TS_WIDTH-1 to 0 with no flag.
- An event carries the ts value before that cycle's increment, i.e. the index of the sample that produced it.

Edge detect:
- candidate = sample_en & spike_in & ~prev_spike.
- prev_spike <= spike_in on every sample_en cycle, regardless of state.

State machine (advances only on sample_en=1):
- ARMED: a candidate is accepted as an event. If REFRACTORY>0, load rcnt=REFRACTORY-1 and go to REFRACT; else stay in ARMED.
- REFRACT: candidates are ignored and not counted as drops. If rcnt==0, go to ARMED; else decrement rcnt. This makes exactly REFRACTORY samples after the event ineligible.
- A level held high produces exactly one event. A new event needs a 0->1 transition after the refractory window.

FIFO push:
- Occurs in the same cycle the event is accepted.
- Earliest ev_valid is the next cycle (latency 1 clk from the sample_en edge).

FIFO full:
- If full and no pop this cycle: event dropped, overflow<=1, drop_count increments.
- If full and pop this cycle (ev_valid & ev_ready): push is accepted and occupancy is unchanged.
- Push and pop on a non-empty, non-full FIFO: both proceed.

Stream:
- ev_valid = FIFO not empty; ev_data = head entry.
- ev_data must stay stable while ev_valid & ~ev_ready.
- Pop on ev_valid & ev_ready.
- ev_valid never depends combinationally on ev_ready.

Counters:
- event_count and drop_count saturate at 2^CNT_WIDTH-1.
- overflow is cleared only by rst.

Decomposition:
- Shared package spike_pkg:
  - default widths (TS_WIDTH, CH_WIDTH)
  - event word layout: channel-ID field MSBs, timestamp field LSBs, with helper constants for field offsets
  - state enum {ARMED, REFRACT}
- One sub-module, event_fifo: synchronous, parameterised width and depth, registered read pointer; push/pop/full/empty/count.
- Refractory FSM, edge detect, timestamp and counters stay in spike_event_packer.

Test Plan:
1. Single event: sample_en every cycle, spike_in rises at sample 5 and stays high 10 samples, ev_ready=1 -> exactly one word {0,24'd5}; ev_valid high for 1 cycle, one clk after the edge; event_count=1.
2. Refractory: REFRACTORY=30, pulses (1 sample high) at samples 10, 25, 41, 42 -> events at 10 and 41 only (25 falls inside the window; 42 is not a new edge); drop_count=0.
3. Backpressure and overflow: FIFO_DEPTH=8, REFRACTORY=0, ev_ready=0, 10 isolated pulses -> first 8 stored, last 2 dropped; overflow=1, drop_count=2. Then ev_ready=1 -> 8 words in order with ev_data stable while stalled.
4. Full with simultaneous pop: FIFO full, event accepted in the same cycle as ev_ready=1 -> new event stored, count stays 8, drop_count unchanged.
5. Timestamp wrap: TS_WIDTH=4, pulses at samples 14 and 17 -> timestamps 14 and 1.
6. Reset mid-operation: rst=1 for one cycle while in REFRACT with 3 FIFO entries -> next cycle ev_valid=0, ts=0, counters=0, overflow=0. An edge on the first sample after reset is accepted with timestamp 0.
